rf_writeback_arbiter: RTL and testbench

Shares the register file's single write port between the ALU writeback path and the load (memory) writeback path of the z8 core. Arbitrates the two requesters with valid/ready handshakes and round-robin priority, registers the winning write onto the register file write port, and keeps a per-register scoreboard of outstanding loads. Also produces a read-after-write stall for the decode stage. Sits between the execute/memory stages and `register_file`.

---
 rtl/instruction_set.sv | 18 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/rf_writeback_arbiter.sv | 95 +++++++++
 tb/tb_rf_writeback_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_set.sv
// Shared z8 core definitions: datapath width, register address width and
// the writeback request types used by the register file write port logic.
package instruction_set;

  localparam int WORD_SIZE  = 16;
  localparam int REG_ADDR_W = 2;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_SIZE-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter for the ALU and load writeback requesters.
// Grants are combinational; last_grant remembers the most recent winner.
module rr_arbiter2
  import instruction_set::*;
(
  input  logic clk,
  input  logic reset,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_grant,
  output logic mem_grant
);

  wb_src_t last_grant;

  // On a tie the port that did not win last time is granted
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        if (last_grant == WB_ALU) mem_grant = 1'b1;
        else                      alu_grant = 1'b1;
      end else begin
        alu_grant = alu_valid;
        mem_grant = mem_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          last_grant <= WB_ALU;
    else if (mem_grant) last_grant <= WB_MEM;
    else if (alu_grant) last_grant <= WB_ALU;
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register file write port arbiter with load scoreboard and decode stall.
// Define RF_WB_FORWARD_EN to forward the registered write to decode instead of stalling.
module rf_writeback_arbiter
  import instruction_set::*;
#(
  parameter int WORD_SIZE = instruction_set::WORD_SIZE,
  parameter int NUM_REGS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [WORD_SIZE-1:0]  alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0]  mem_data,
  input  logic                  sb_set_en,
  input  logic [REG_ADDR_W-1:0] sb_set_addr,
  input  logic [REG_ADDR_W-1:0] src_a_addr,
  input  logic [REG_ADDR_W-1:0] src_b_addr,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
`ifdef RF_WB_FORWARD_EN
  output logic [WORD_SIZE-1:0]  rf_write_data,
  output logic                  fwd_a_valid,
  output logic                  fwd_b_valid,
  output logic [WORD_SIZE-1:0]  fwd_a_data,
  output logic [WORD_SIZE-1:0]  fwd_b_data
`else
  output logic [WORD_SIZE-1:0]  rf_write_data
`endif
);

  logic                alu_xfer;
  logic                mem_xfer;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                wb_hit;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .alu_grant (alu_ready),
    .mem_grant (mem_ready)
  );

  assign alu_xfer = alu_valid & alu_ready;
  assign mem_xfer = mem_valid & mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= alu_xfer | mem_xfer;
      if (mem_xfer) begin
        rf_write_addr <= mem_addr;
        rf_write_data <= mem_data;
      end else if (alu_xfer) begin
        rf_write_addr <= alu_addr;
        rf_write_data <= alu_data;
      end
    end
  end

  // Set is applied after clear so a same-cycle reservation survives
  assign set_mask = sb_set_en ? (NUM_REGS'(1) << sb_set_addr) : '0;
  assign clr_mask = mem_xfer  ? (NUM_REGS'(1) << mem_addr)    : '0;

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

`ifdef RF_WB_FORWARD_EN
  assign fwd_a_valid = rf_write_enable & (rf_write_addr == src_a_addr);
  assign fwd_b_valid = rf_write_enable & (rf_write_addr == src_b_addr);
  assign fwd_a_data  = rf_write_data;
  assign fwd_b_data  = rf_write_data;
  assign wb_hit      = 1'b0;
`else
  assign wb_hit = rf_write_enable &
                  ((rf_write_addr == src_a_addr) | (rf_write_addr == src_b_addr));
`endif

  assign stall = pending[src_a_addr] | pending[src_b_addr] | wb_hit;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, sb_set_en;
  logic        alu_ready, mem_ready, stall, rf_write_enable;
  logic [1:0]  alu_addr, mem_addr, sb_set_addr, src_a_addr, src_b_addr, rf_write_addr;
  logic [15:0] alu_data, mem_data, rf_write_data;
  logic [3:0]  pending;
`ifdef RF_WB_FORWARD_EN
  logic        fwd_a_valid, fwd_b_valid;
  logic [15:0] fwd_a_data, fwd_b_data;
`endif

  int checks = 0;
  int errors = 0;

  // Model state
  bit          exp_we;
  bit [1:0]    exp_waddr;
  bit [15:0]   exp_wdata;
  bit          pend [4];
  bit          last_was_mem;
  bit          alu_xfer, mem_xfer;

  rf_writeback_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .sb_set_en       (sb_set_en),
    .sb_set_addr     (sb_set_addr),
    .src_a_addr      (src_a_addr),
    .src_b_addr      (src_b_addr),
    .stall           (stall),
    .pending         (pending),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
`ifdef RF_WB_FORWARD_EN
    .rf_write_data   (rf_write_data),
    .fwd_a_valid     (fwd_a_valid),
    .fwd_b_valid     (fwd_b_valid),
    .fwd_a_data      (fwd_a_data),
    .fwd_b_data      (fwd_b_data)
`else
    .rf_write_data   (rf_write_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT against the model, then advance the model at the edge
  task automatic applyStimulus();
    bit ga, gm, es;
    bit [3:0] pv;
    #1;
    ga = !reset && alu_valid && (!mem_valid || last_was_mem);
    gm = !reset && mem_valid && (!alu_valid || !last_was_mem);
    es = pend[src_a_addr] || pend[src_b_addr];
`ifndef RF_WB_FORWARD_EN
    es = es || (exp_we && (exp_waddr == src_a_addr || exp_waddr == src_b_addr));
`endif
    for (int i = 0; i < 4; i++) pv[i] = pend[i];
    checkOutput("alu_ready", alu_ready, ga);
    checkOutput("mem_ready", mem_ready, gm);
    checkOutput("stall", stall, es);
    checkOutput("pending", pending, pv);
    checkOutput("rf_write_enable", rf_write_enable, exp_we);
    checkOutput("rf_write_addr", rf_write_addr, exp_waddr);
    checkOutput("rf_write_data", rf_write_data, exp_wdata);
`ifdef RF_WB_FORWARD_EN
    checkOutput("fwd_a_valid", fwd_a_valid, exp_we && exp_waddr == src_a_addr);
    checkOutput("fwd_b_valid", fwd_b_valid, exp_we && exp_waddr == src_b_addr);
    checkOutput("fwd_a_data", fwd_a_data, exp_wdata);
    checkOutput("fwd_b_data", fwd_b_data, exp_wdata);
`endif
    @(posedge clk);
    if (reset) begin
      exp_we = 0; exp_waddr = 0; exp_wdata = 0; last_was_mem = 0;
      for (int i = 0; i < 4; i++) pend[i] = 0;
    end else begin
      exp_we = ga || gm;
      if (ga) begin exp_waddr = alu_addr; exp_wdata = alu_data; last_was_mem = 0; end
      if (gm) begin exp_waddr = mem_addr; exp_wdata = mem_data; last_was_mem = 1; end
      if (gm) pend[mem_addr] = 0;
      if (sb_set_en) pend[sb_set_addr] = 1;
    end
    alu_xfer = ga;
    mem_xfer = gm;
    @(negedge clk);
  endtask

  initial begin
    reset = 1; alu_valid = 1; mem_valid = 1; sb_set_en = 0;
    alu_addr = 0; mem_addr = 0; sb_set_addr = 0; src_a_addr = 0; src_b_addr = 0;
    alu_data = 0; mem_data = 0;
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput("reset alu_ready", alu_ready, 0);
    checkOutput("reset mem_ready", mem_ready, 0);
    checkOutput("reset pending", pending, 0);
    checkOutput("reset we", rf_write_enable, 0);
    checkOutput("reset stall", stall, 0);
    applyStimulus();
    reset = 0; mem_valid = 0;

    // ALU-only write
    alu_addr = 2; alu_data = 16'hBEEF;
    #1 checkOutput("alu only ready", alu_ready, 1);
    applyStimulus();
    alu_valid = 0;
    #1;
    checkOutput("alu wr en", rf_write_enable, 1);
    checkOutput("alu wr addr", rf_write_addr, 2);
    checkOutput("alu wr data", rf_write_data, 16'hBEEF);
    applyStimulus();
    #1 checkOutput("alu wr en off", rf_write_enable, 0);
    applyStimulus();

    // Both held valid: mem, alu, mem, alu
    alu_valid = 1; alu_addr = 1; alu_data = 16'h1111;
    mem_valid = 1; mem_addr = 3; mem_data = 16'h3333;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("tie mem_ready", mem_ready, (k % 2 == 0));
      checkOutput("tie alu_ready", alu_ready, (k % 2 == 1));
      if (k > 0) checkOutput("tie wr addr", rf_write_addr, (k % 2 == 1) ? 3 : 1);
      applyStimulus();
    end
    alu_valid = 0; mem_valid = 0;
    #1 checkOutput("tie last wr data", rf_write_data, 16'h1111);
    applyStimulus();

    // Scoreboard stall on load destination
    sb_set_en = 1; sb_set_addr = 3;
    applyStimulus();
    sb_set_en = 0; src_a_addr = 3; src_b_addr = 0;
    #1 checkOutput("sb stall", stall, 1);
    applyStimulus();
    mem_valid = 1; mem_addr = 3; mem_data = 16'h5A5A;
    #1 checkOutput("sb stall hold", stall, 1);
    applyStimulus();
    mem_valid = 0;
    #1 checkOutput("sb cleared", pending[3], 0);
    applyStimulus();
    #1 checkOutput("sb stall released", stall, 0);
    applyStimulus();

    // Same-cycle set and clear: set wins
    src_a_addr = 2; src_b_addr = 2;
    sb_set_en = 1; sb_set_addr = 1;
    applyStimulus();
    mem_valid = 1; mem_addr = 1; mem_data = 16'h0101;
    applyStimulus();
    sb_set_en = 0; mem_valid = 0;
    #1 checkOutput("set wins", pending[1], 1);
    mem_valid = 1;
    applyStimulus();
    mem_valid = 0;
    #1 checkOutput("clear alone", pending[1], 0);
    applyStimulus();

    // Registered write to a decode source
    alu_valid = 1; alu_addr = 0; alu_data = 16'hCAFE; src_a_addr = 2; src_b_addr = 0;
    applyStimulus();
    alu_valid = 0;
    #1;
`ifdef RF_WB_FORWARD_EN
    checkOutput("fwd_b_valid hit", fwd_b_valid, 1);
    checkOutput("fwd_b_data hit", fwd_b_data, 16'hCAFE);
    checkOutput("fwd no stall", stall, 0);
`else
    checkOutput("wb_hit stall", stall, 1);
`endif
    applyStimulus();
    #1 checkOutput("wb_hit one cycle", stall, 0);
    applyStimulus();

    // Reset with pending loads and a write in flight
    sb_set_en = 1; sb_set_addr = 1;
    applyStimulus();
    sb_set_addr = 3; alu_valid = 1; alu_addr = 2; alu_data = 16'h7777;
    applyStimulus();
    sb_set_en = 0; alu_valid = 0;
    #1;
    checkOutput("pre-reset pending", pending, 4'b1010);
    checkOutput("pre-reset we", rf_write_enable, 1);
    reset = 1; alu_valid = 1; mem_valid = 1;
    applyStimulus();
    #1;
    checkOutput("mid reset pending", pending, 0);
    checkOutput("mid reset we", rf_write_enable, 0);
    checkOutput("mid reset alu_ready", alu_ready, 0);
    checkOutput("mid reset mem_ready", mem_ready, 0);
    applyStimulus();
    reset = 0; alu_valid = 0; mem_valid = 0;

    // Randomized traffic; requesters hold until their transfer completes
    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      reset = ($urandom_range(99) < 2);
      if (!alu_valid || alu_xfer) begin
        alu_valid = ($urandom_range(99) < 60);
        alu_addr  = 2'($urandom);
        alu_data  = 16'($urandom);
      end
      if (!mem_valid || mem_xfer) begin
        mem_valid = ($urandom_range(99) < 50);
        mem_addr  = 2'($urandom);
        mem_data  = 16'($urandom);
      end
      sb_set_en   = ($urandom_range(99) < 30);
      sb_set_addr = 2'($urandom);
      src_a_addr  = 2'($urandom);
      src_b_addr  = 2'($urandom);
    end
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
